// File: rtl/mem_stage.sv
// ============================================================================
// mem_stage : memory-access stage with integrated MEM/WB register
// Revision  : 1.0
// ============================================================================
`default_nettype none

module mem_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ALUResultIn,
  input  logic [DATA_W-1:0] StoreData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWriteIn,
  input  logic [REG_W-1:0]  RdIn,
  input  logic              DataInputSIn,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] Data5,
  output logic [DATA_W-1:0] ALUResult,
  output logic              DataInputS,
  output logic              RegWriteOut,
  output logic [REG_W-1:0]  RdOut,
  output logic              mem_err
);

  localparam logic [0:0] c_IDLE   = 1'b0;
  localparam logic [0:0] c_ACCESS = 1'b1;
  localparam int         c_CNT_W  = $clog2(TIMEOUT + 1);
  localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(TIMEOUT);

  logic [0:0]         r_state;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_req;
  logic               r_we;
  logic [DATA_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [REG_W-1:0]   r_p_rd;
  logic               r_p_dis;
  logic               r_p_rw;
  logic               r_out_valid;
  logic               r_mem_err;
  logic               r_regwr;
  logic [DATA_W-1:0]  r_data5;
  logic [DATA_W-1:0]  r_alu;
  logic               r_dis;
  logic [REG_W-1:0]   r_rd;

  logic               w_accept;
  logic               w_mem_op;
  logic               w_misaligned;
  logic [c_CNT_W-1:0] w_cnt_next;

  assign in_ready     = (r_state == c_IDLE);
  assign w_accept     = in_valid & in_ready;
  assign w_mem_op     = MemRead | MemWrite;
  assign w_misaligned = |ALUResultIn[1:0];
  assign w_cnt_next   = r_cnt + 1'b1;

  // Pending fields are kept apart from the WB outputs so those hold their
  // last value while an access is outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_IDLE;
      r_cnt       <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_p_rd      <= '0;
      r_p_dis     <= 1'b0;
      r_p_rw      <= 1'b0;
      r_out_valid <= 1'b0;
      r_mem_err   <= 1'b0;
      r_regwr     <= 1'b0;
      r_data5     <= '0;
      r_alu       <= '0;
      r_dis       <= 1'b0;
      r_rd        <= '0;
    end else begin
      r_out_valid <= 1'b0;
      r_mem_err   <= 1'b0;
      r_regwr     <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            if (w_mem_op && !w_misaligned) begin
              r_state <= c_ACCESS;
              r_cnt   <= '0;
              r_req   <= 1'b1;
              r_we    <= MemWrite;
              r_addr  <= ALUResultIn;
              r_wdata <= StoreData;
              r_p_rd  <= RdIn;
              r_p_dis <= DataInputSIn;
              r_p_rw  <= RegWriteIn;
            end else begin
              r_out_valid <= 1'b1;
              r_alu       <= ALUResultIn;
              r_rd        <= RdIn;
              r_dis       <= DataInputSIn;
              r_regwr     <= RegWriteIn & ~w_mem_op;
              r_mem_err   <= w_mem_op;
            end
          end
        end
        c_ACCESS: begin
          if (dmem_ack || (w_cnt_next == c_TIMEOUT)) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_req       <= 1'b0;
            r_out_valid <= 1'b1;
            r_alu       <= r_addr;
            r_rd        <= r_p_rd;
            r_dis       <= r_p_dis;
            r_regwr     <= dmem_ack & r_p_rw & ~r_we;
            r_mem_err   <= ~dmem_ack;
            if (dmem_ack && !r_we) begin
              r_data5 <= dmem_rdata;
            end
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign dmem_req    = r_req;
  assign dmem_we     = r_we;
  assign dmem_addr   = r_addr;
  assign dmem_wdata  = r_wdata;
  assign out_valid   = r_out_valid;
  assign Data5       = r_data5;
  assign ALUResult   = r_alu;
  assign DataInputS  = r_dis;
  assign RegWriteOut = r_regwr;
  assign RdOut       = r_rd;
  assign mem_err     = r_mem_err;

endmodule

`default_nettype wire
